// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out: double-buffered 160x120 RRRGGGBB image shown at 4x,
// three-stage pipeline from timing-generator coordinates to DAC pins.
module vga_fb_scanout #(
    parameter int unsigned FB_W      = 160,
    parameter int unsigned FB_H      = 120,
    parameter int unsigned SWAP_LINE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  sx,
    input  logic [9:0]  sy,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swapped,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de
);

    localparam int unsigned DEPTH    = FB_W * FB_H;
    localparam logic [14:0] LP_DEPTH = 15'(DEPTH);
    localparam logic [9:0]  LP_SWAP  = 10'(SWAP_LINE);

    logic [7:0]  r_bank0 [DEPTH];
    logic [7:0]  r_bank1 [DEPTH];

    logic        r_front;
    logic        r_pending;

    logic [14:0] r_s1_addr;
    logic        r_s1_front;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_de;

    logic [7:0]  r_rd_data;
    logic        r_s2_hs;
    logic        r_s2_vs;
    logic        r_s2_de;

    logic [7:0]  w_row;
    logic [14:0] w_rd_addr;
    logic        w_commit;
    logic        w_do_swap;
    logic        w_wr_en;

    // row*160 as row*128 + row*32, no multiplier needed
    assign w_row     = sy[9:2];
    assign w_rd_addr = {w_row, 7'd0}
                     + {2'd0, w_row, 5'd0}
                     + {7'd0, sx[9:2]};

    assign w_commit  = (sx == 10'd0) && (sy == LP_SWAP);
    assign w_do_swap = w_commit && (r_pending || swap_req);

    assign wr_ready     = ~r_pending;
    assign swap_pending = r_pending;
    assign swapped      = w_do_swap & ~reset;

    assign w_wr_en = wr_valid & wr_ready & ~reset
                   & (wr_addr < LP_DEPTH);

    // writes use the pre-toggle front, so a commit-cycle write hits the old back bank
    always_ff @(posedge clk) begin
        if (w_wr_en && r_front) begin
            r_bank0[wr_addr] <= wr_data;
        end
        if (w_wr_en && !r_front) begin
            r_bank1[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= 8'd0;
        end else if (r_s1_front) begin
            r_rd_data <= r_bank1[r_s1_addr];
        end else begin
            r_rd_data <= r_bank0[r_s1_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_do_swap) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
        end else if (swap_req) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_addr  <= 15'd0;
            r_s1_front <= 1'b0;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
            r_s1_de    <= 1'b0;
            r_s2_hs    <= 1'b1;
            r_s2_vs    <= 1'b1;
            r_s2_de    <= 1'b0;
        end else begin
            r_s1_addr  <= de_in ? w_rd_addr : 15'd0;
            r_s1_front <= r_front;
            r_s1_hs    <= hsync_in;
            r_s1_vs    <= vsync_in;
            r_s1_de    <= de_in;
            r_s2_hs    <= r_s1_hs;
            r_s2_vs    <= r_s1_vs;
            r_s2_de    <= r_s1_de;
        end
    end

    // replicate MSBs so full-scale 3/2-bit codes reach 0xF
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r <= 4'd0;
            vga_g <= 4'd0;
            vga_b <= 4'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else begin
            vga_r <= r_s2_de ? {r_rd_data[7:5], r_rd_data[7]} : 4'd0;
            vga_g <= r_s2_de ? {r_rd_data[4:2], r_rd_data[4]} : 4'd0;
            vga_b <= r_s2_de ? {r_rd_data[1:0], r_rd_data[1:0]} : 4'd0;
            hsync <= r_s2_hs;
            vsync <= r_s2_vs;
            de    <= r_s2_de;
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed/random bench for vga_fb_scanout against a frame-level
// reference model (two image arrays, front flag, delayed expectation queue).
module tb_vga_fb_scanout;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic        swapped;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        de;

    always #5 clk = ~clk;

    vga_fb_scanout dut (
        .clk          (clk),
        .reset        (reset),
        .sx           (sx),
        .sy           (sy),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .de_in        (de_in),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swapped      (swapped),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de)
    );

    localparam logic [14:0] RST_OUT = 15'b000000000000_1_1_0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  img [2][19200];
    bit          front_m = 1'b0;
    bit          pend_m  = 1'b0;
    logic [14:0] q[$];
    int          rows[5] = '{0, 1, 60, 118, 119};
    int          lines[7] = '{0, 3, 4, 241, 472, 479, 490};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scale a 3-bit (or 2-bit) level to 4 bits as arithmetic
    function automatic logic [11:0] expand(input logic [7:0] p);
        int r;
        int g;
        int b;
        r = int'(p) / 32;
        g = (int'(p) / 4) % 8;
        b = int'(p) % 4;
        return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
    endfunction

    task automatic step(input int x, input int y, input bit req,
                        input bit wv, input int wa,
                        input logic [7:0] wd, input bit rst);
        bit          de_e;
        bit          hs_e;
        bit          vs_e;
        bit          exp_sw;
        bit          acc;
        logic [11:0] col;
        logic [14:0] e;
        de_e = (x < 640) && (y < 480);
        hs_e = !((x >= 656) && (x < 752));
        vs_e = !((y >= 490) && (y < 492));
        sx       = 10'(x);
        sy       = 10'(y);
        hsync_in = hs_e;
        vsync_in = vs_e;
        de_in    = de_e;
        swap_req = req;
        wr_valid = wv;
        wr_addr  = 15'(wa);
        wr_data  = wd;
        reset    = rst;
        exp_sw = !rst && (x == 0) && (y == 480) && (pend_m || req);
        #1;
        if (!rst) begin
            check("wr_ready", wr_ready, !pend_m);
            check("swapped", swapped, exp_sw);
        end
        col = 12'd0;
        if (de_e) col = expand(img[front_m][(y / 4) * 160 + x / 4]);
        e   = {col, hs_e, vs_e, de_e};
        acc = wv && !pend_m && !rst;
        @(posedge clk);
        if (rst) begin
            q       = {RST_OUT, RST_OUT};
            front_m = 1'b0;
            pend_m  = 1'b0;
            e       = RST_OUT;
        end else begin
            q.push_back(e);
            e = q.pop_front();
            if (acc && wa < 19200) img[!front_m][wa] = wd;
            if (exp_sw) begin
                front_m = !front_m;
                pend_m  = 1'b0;
            end else if (req) begin
                pend_m = 1'b1;
            end
        end
        #1;
        check("pixel_out", {vga_r, vga_g, vga_b, hsync, vsync, de}, e);
        check("swap_pending", swap_pending, pend_m);
    endtask

    task automatic idle();
        step(700, 500, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic fill_rows();
        foreach (rows[i]) begin
            for (int x = 0; x < 160; x++) begin
                step(700, 500, 1'b0, 1'b1, rows[i] * 160 + x,
                     8'($urandom), 1'b0);
            end
        end
    endtask

    task automatic scan(input bit rw);
        foreach (lines[i]) begin
            for (int x = 0; x < 800; x++) begin
                bit wv;
                wv = rw && ($urandom % 2 == 0);
                step(x, lines[i], 1'b0, wv, int'($urandom_range(19300, 0)),
                     8'($urandom), 1'b0);
            end
        end
    endtask

    task automatic probe(input string tag, input int x, input int y,
                         input logic [11:0] rgb);
        step(x, y, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        idle();
        idle();
        check(tag, {vga_r, vga_g, vga_b}, rgb);
    endtask

    initial begin
        q = {RST_OUT, RST_OUT};
        for (int i = 0; i < 3; i++) step(700, 500, 1'b0, 1'b0, 0, 8'h00, 1'b1);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_de", de, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_pending", swap_pending, 0);

        fill_rows();
        step(0, 480, 1'b1, 1'b1, 1, 8'h5A, 1'b0);
        check("boundary_pending", swap_pending, 0);
        check("boundary_ready", wr_ready, 1);
        fill_rows();
        scan(1'b1);

        step(700, 500, 1'b0, 1'b1, 0, 8'hE0, 1'b0);
        step(700, 500, 1'b0, 1'b1, 19199, 8'h1C, 1'b0);
        step(700, 500, 1'b0, 1'b1, 60 * 160 + 10, 8'hB6, 1'b0);
        step(700, 500, 1'b0, 1'b1, 19200, 8'hFF, 1'b0);

        for (int x = 0; x < 10; x++) begin
            step(x, 100, x == 5, x == 5, 2, 8'h03, 1'b0);
        end
        check("hs_pending", swap_pending, 1);
        check("hs_ready", wr_ready, 0);
        for (int x = 0; x < 20; x++) begin
            step(x, 150, 1'b0, 1'b1, (x % 2 == 0) ? 0 : 19199, 8'h00, 1'b0);
        end
        step(3, 200, 1'b1, 1'b0, 0, 8'h00, 1'b0);
        check("second_req_pending", swap_pending, 1);
        step(0, 480, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        check("commit_pending", swap_pending, 0);
        check("commit_ready", wr_ready, 1);
        step(1, 480, 1'b0, 1'b0, 0, 8'h00, 1'b0);

        probe("red_tl", 0, 0, 12'hF00);
        probe("red_tl33", 3, 3, 12'hF00);
        probe("green_br_a", 636, 476, 12'h0F0);
        probe("green_br_b", 639, 479, 12'h0F0);
        probe("expand_b6", 41, 242, 12'hBBA);
        probe("req_cycle_wr", 8, 0, 12'h00F);
        scan(1'b1);

        step(10, 50, 1'b1, 1'b0, 0, 8'h00, 1'b0);
        step(11, 50, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        check("mid_pending", swap_pending, 1);
        step(12, 50, 1'b0, 1'b1, 0, 8'h11, 1'b1);
        check("mid_rst_pending", swap_pending, 0);
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        check("mid_rst_de", de, 0);
        for (int x = 13; x < 16; x++) step(x, 50, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        step(0, 480, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        probe("front_kept", 2, 1, 12'hF00);
        probe("after_rst_exp", 42, 243, 12'hBBA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
# vga_fb_scanout

Framebuffer scan-out stage sitting directly downstream of the VGA timing generator. Consumes its `sx`/`sy`/`hsync`/`vsync`/`de` stream and holds a double-buffered 160x120, 8-bit RRRGGGBB framebuffer. The framebuffer is shown at 4x scale on the 640x480 display. Drives 4-bit-per-channel RGB plus pipeline-aligned sync and data-enable to the DAC/pins, and exposes a ready/valid pixel write port and a vblank-synchronised buffer swap.

## Interface
- `FB_W`, 160: framebuffer width in pixels (fixed 640/4).
- `FB_H`, 120: framebuffer height in pixels (fixed 480/4).
- `SWAP_LINE`, 480: `sy` value at which a pending swap is committed (first blanking line).
- `clk`  in  1  pixel clock, same domain as the timing generator.
- `reset`  in  1  synchronous, active-high reset.
- `sx`  in  10  horizontal position from timing generator.
- `sy`  in  10  vertical position from timing generator.
- `hsync_in`, `vsync_in`  in  1 each  active-low syncs from timing generator.
- `de_in`  in  1  data enable from timing generator.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  15  linear pixel address y*160+x into the back buffer.
- `wr_data`  in  8  pixel, [7:5]=R, [4:2]=G, [1:0]=B.
- `swap_req`  in  1  one-cycle request to exchange front/back buffers at next swap point.
- `swap_pending`  out  1  swap requested, not yet committed.
- `swapped`  out  1  one-cycle pulse on the commit cycle.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour output.
- `hsync`, `vsync`  out  1 each  syncs delayed to match colour.
- `de`  out  1  data enable delayed to match colour.

## Operation
- Two 19200x8 RAM banks. `front` bit (reset 0) selects the scan-out bank; the other is the back bank, the write target.
- Read address: `(sy>>2)*160 + (sx>>2)`, computed as `((sy>>2)<<7) + ((sy>>2)<<5) + (sx>>2)` in 15 bits. Always fits, max 19199. Computed only meaningfully when `de_in`; value outside active is don't-care.
- Pipeline: S1 registers address, `front`, syncs, de. S2 registers RAM read data (synchronous read) and delayed controls. S3 registers colour expansion and outputs.
- Colour expansion: R4={R[2:0],R[2]}, G4={G[2:0],G[2]}, B4={B[1:0],B[1:0]}. Output 0 on all channels when delayed de is 0.
- Write port: `wr_ready = ~swap_pending` (combinational). An accepted write with `wr_addr` ≥ 19200 completes the handshake but modifies no memory.
- Swap: `swap_req` sets `swap_pending`. Commit point is the cycle with `sx==0 && sy==SWAP_LINE`. On commit, if `swap_pending || swap_req`: toggle `front`, clear `swap_pending`, pulse `swapped`.
- `swap_req` while already pending: no effect (no double toggle).
- A write accepted in the same cycle as `swap_req` lands in the current back bank. It is accepted because `wr_ready` is still 1 that cycle.
- A write accepted on the commit cycle itself (only possible when `swap_req` arrives there) lands in the pre-toggle back bank.

## Timing
- Latency `sx`/`sy`/`de_in`/syncs → `vga_*`/`de`/`hsync`/`vsync`: exactly 3 cycles, all outputs aligned.
- Write-to-visible: a pixel written to the back bank is visible only after the next commit.
- `front` sampled into S1 travels with its address. Pixels already in flight at commit read the old bank. Commit is in blanking, so the visible result is unaffected.
- Reset values (the cycle after `reset` is high):
  - `vga_r/g/b` = 0, `de` = 0, `hsync` = 1, `vsync` = 1.
  - `front` = 0, `swap_pending` = 0, `swapped` = 0, `wr_ready` = 1.
  - Pipeline registers cleared. RAM contents are not reset.
- Reset mid-frame: pending swap cancelled, outputs take reset values immediately, in-flight writes dropped. Normal output resumes 3 cycles after `reset` deasserts.

## Test plan
- Sync alignment: free-run the timing generator after reset → `hsync`/`vsync`/`de` equal `hsync_in`/`vsync_in`/`de_in` delayed by exactly 3 cycles for a full 800x525 frame. RGB is 0 wherever `de`=0.
- Scale/address: write 0xE0 to back addr 0 and 0x1C to addr 19199, then pulse `swap_req` → after `swapped`, screen pixels (0..3,0..3) show R=0xF,G=0,B=0. Pixels (636..639,476..479) show G=0xF. All others show the prior bank content.
- Colour expand: pixel 0xB6 (R=101,G=101,B=10) → outputs R=0xB, G=0xB, B=0xA.
- Swap handshake: `swap_req` at sy=100 → `swap_pending`=1 and `wr_ready`=0 until sx=0,sy=480. `swapped` pulses there for 1 cycle, then `wr_ready`=1. A second `swap_req` at sy=200 causes no extra toggle.
- Boundary: `swap_req` exactly at sx=0,sy=480 → commits the same cycle with no pending cycle. Write to `wr_addr`=19200 → handshake completes, no RAM change.
- Reset mid-frame with swap pending → `front` unchanged from 0, `swap_pending`=0, syncs high and `de`=0 next cycle.
